retire_sync_n: RTL
==================

Name: retire_sync_n

Overview:
- Generalised retirement aligner for N-way relational verification: N cores, each clocked through a per-channel clock enable.
- Every active core runs until it retires one instruction, then it is frozen until all active cores have retired.
- Once all have retired, the block issues a single aligned retire pulse to the contract and observation checkers.
- Adds channel masking, a straggler timeout with divergence reporting, and an aligned-retirement counter.

Parameters:
- N_CORES, 2, number of lockstepped core instances (≥1).
- TIMEOUT, 64, maximum cycles to wait for stragglers after the first retirement of a round (≥1).
- CNT_W, 32, width of the aligned-retirement counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- active_i  in  N_CORES  per-channel participation mask; a 0 excludes the channel from alignment.
- retire_i  in  N_CORES  per-core retire strobe (rvfi_valid); only meaningful when that channel's enable is 1.
- clk_en_o  out  N_CORES  per-core clock enable; the top gates each core/memory clock with it.
- retire_o  out  1  one-cycle pulse: all active cores have retired one instruction.
- retire_count_o  out  CNT_W  number of retire_o pulses since reset.
- timeout_o  out  1  sticky: the straggler wait exceeded TIMEOUT.
- diverge_mask_o  out  N_CORES  channels that had not retired when the timeout fired; held while timeout_o=1.

Behaviour:
- Reset (async assert, sync release): state=RUN, retired_q=0, wait counter=0, retire_o=0, retire_count_o=0, timeout_o=0, diverge_mask_o=0.
- States:
  - RUN: channels running or waiting.
  - ALIGN: one cycle, emits retire_o.
  - TIMED_OUT: sticky until reset.
- Clock enables:
  - clk_en_o[k] = (state==RUN) & active_i[k] & ~retired_q[k].
  - Combinational from registers plus active_i; no other inputs feed it.
  - All enables are 0 in ALIGN and TIMED_OUT.
- RUN:
  - For each k with clk_en_o[k]=1 and retire_i[k]=1, set retired_q[k] at the clock edge.
  - retire_i[k] with clk_en_o[k]=0 is ignored.
  - When (retired_q_next & active_i) == active_i and active_i != 0, go to ALIGN.
  - Simultaneous retirement of all active channels in one cycle goes straight to ALIGN.
  - active_i == 0: stay in RUN; never ALIGN.
- ALIGN:
  - retire_o=1 for exactly one cycle.
  - retire_count_o increments, wrapping at 2^CNT_W.
  - retired_q and the wait counter clear.
  - Next state is RUN.
- Latency: last retire strobe at edge t → retire_o high in cycle t+1 → clk_en_o high again in cycle t+2.
- Wait counter:
  - Increments each RUN cycle in which (retired_q & active_i) != 0.
  - Clears in ALIGN.
  - Saturates.
  - When it equals TIMEOUT while still in RUN, next state is TIMED_OUT: timeout_o=1, diverge_mask_o = active_i & ~retired_q captured at that edge.
- Completion wins: if the last retirement arrives in the same cycle the counter reaches TIMEOUT, go to ALIGN, not TIMED_OUT.
- active_i changes mid-round:
  - Clearing active_i[k] clears retired_q[k] next edge and drops k from the completion check; this may complete the round immediately.
  - Setting active_i[k] adds k to the current round, not yet retired.
- TIMED_OUT: only rst_i leaves it; retire_count_o holds.
- N_CORES=1: every accepted retire yields ALIGN (a 2-cycle round); timeout never fires.

Test Plan (N_CORES=3, TIMEOUT=8, CNT_W=32):
1. Reset, active_i=3'b111, all three retire_i pulse on the same enabled cycle → retire_o=1 next cycle, clk_en_o=000 that cycle, then 111; retire_count_o=1.
2. Core 0 retires at cycle 2, core 2 at cycle 4, core 1 at cycle 5 → clk_en_o goes 110, then 010, then 000; retire_o at cycle 6; count=1; timeout_o=0.
3. Core 0 retires and cores 1 and 2 never retire → after 8 waiting cycles timeout_o=1, diverge_mask_o=3'b110, clk_en_o=000 held; further retire_i ignored until rst_i.
4. active_i=3'b101, cores 0 and 2 retire, with retire_i[1] held at 1 → retire_o pulses; clk_en_o[1]=0 throughout; core 1 strobe ignored.
5. Core 0 retired and waiting, core 1 retired; drop active_i[2] → ALIGN the next cycle, retire_o=1, count increments.
6. Assert rst_i asynchronously mid-round with retired_q=3'b011 → all outputs at reset values immediately, clk_en_o=111 after release. Separately, preload the counter to 2^32−1 and trigger one round → retire_count_o wraps to 0.

Source files
------------

// File: rtl/retire_sync_n.sv
// N-way retirement aligner: each active core runs until it retires one instruction,
// then is frozen until every active core has retired; a single aligned pulse follows.
module retire_sync_n #(
  parameter int N_CORES = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CORES-1:0] active_i,
  input  logic [N_CORES-1:0] retire_i,
  output logic [N_CORES-1:0] clk_en_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   retire_count_o,
  output logic               timeout_o,
  output logic [N_CORES-1:0] diverge_mask_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RUN, ALIGN, TIMED_OUT} state_t;

  state_t             state_reg, state_next;
  logic [N_CORES-1:0] retired_reg, retired_next;
  logic [N_CORES-1:0] diverge_reg, diverge_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               timeout_reg, timeout_next;
  logic [N_CORES-1:0] accept;

  // Enables depend only on registered state and the participation mask.
  assign clk_en_o       = (state_reg == RUN) ? (active_i & ~retired_reg) : '0;
  assign accept         = clk_en_o & retire_i;
  assign retire_o       = (state_reg == ALIGN);
  assign retire_count_o = count_reg;
  assign timeout_o      = timeout_reg;
  assign diverge_mask_o = diverge_reg;

  always_comb begin
    state_next   = state_reg;
    retired_next = retired_reg;
    diverge_next = diverge_reg;
    wait_next    = wait_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      RUN: begin
        // Dropping a channel from active_i also forgets its retirement.
        retired_next = (retired_reg | accept) & active_i;
        if (((retired_reg & active_i) != '0) && (wait_reg != WAIT_LIM))
          wait_next = wait_reg + WAIT_ONE;
        // Completion takes priority over a coincident timeout.
        if ((active_i != '0) && ((retired_next & active_i) == active_i)) begin
          state_next = ALIGN;
        end else if (wait_reg == WAIT_LIM) begin
          state_next   = TIMED_OUT;
          timeout_next = 1'b1;
          diverge_next = active_i & ~retired_reg;
        end
      end
      ALIGN: begin
        retired_next = '0;
        wait_next    = '0;
        count_next   = count_reg + CNT_ONE;
        state_next   = RUN;
      end
      TIMED_OUT: begin
        state_next = TIMED_OUT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= RUN;
      retired_reg <= '0;
      diverge_reg <= '0;
      wait_reg    <= '0;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      retired_reg <= retired_next;
      diverge_reg <= diverge_next;
      wait_reg    <= wait_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end

endmodule
